// File: rtl/dbus_responder.sv
// SRAM-backed data-bus responder with deterministic request-to-completion latency.
// Optional macro DBUS_RESP_ERR_EN adds resp_err for misaligned or out-of-range accesses.
module dbus_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data
`ifdef DBUS_RESP_ERR_EN
    ,
    output logic        resp_err
`endif
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [60:0] DEPTH_L = 61'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t       state_r, state_s;
    logic [3:0]   cnt_r, cnt_s;
    logic         turn_r;
    logic [63:0]  addr_r;
    logic [2:0]   size_r;
    logic [7:0]   strobe_r;
    logic [63:0]  data_r;
    logic         addr_ok_r, data_ok_r;
    logic [63:0]  rdata_r;
    logic [63:0]  offset_s;
    logic         in_range_s;
    logic         access_ok_s;
    logic         is_write_s;
    logic         accept_s;
    logic [IDX_W-1:0] idx_s;
    logic [63:0]  mem [DEPTH_WORDS];

    function automatic logic misaligned(input logic [63:0] a, input logic [2:0] sz);
        case (sz)
            3'd0:    return 1'b0;
            3'd1:    return a[0];
            3'd2:    return |a[1:0];
            default: return |a[2:0];
        endcase
    endfunction

    // Address decode of the latched request.
    always_comb begin
        offset_s   = addr_r - BASE_ADDR;
        in_range_s = (addr_r >= BASE_ADDR) && (offset_s[63:3] < DEPTH_L);
        idx_s      = offset_s[IDX_W+2:3];
        is_write_s = |strobe_r;
`ifdef DBUS_RESP_ERR_EN
        access_ok_s = in_range_s && !misaligned(addr_r, size_r);
`else
        access_ok_s = in_range_s;
`endif
    end

`ifdef DBUS_RESP_ERR_EN
    logic unused_s;
    assign unused_s = ^offset_s[2:0];
`else
    logic unused_s;
    assign unused_s = ^{offset_s[2:0], size_r};
`endif

    // The idle cycle right after completion is a turnaround: req_valid is not sampled there.
    assign accept_s = (state_r == IDLE) && req_valid && !turn_r;

    // Next-state and latency counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ACK;
                end else begin
                    state_s = IDLE;
                end
            end
            ACK: begin
                cnt_s = LAT_M1;
                if (LATENCY == 1) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, counter and turnaround registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            turn_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            turn_r  <= (state_r == DONE);
        end
    end

    // Request capture; later changes on req_* are ignored until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r   <= 64'd0;
            size_r   <= 3'd0;
            strobe_r <= 8'd0;
            data_r   <= 64'd0;
        end else if (accept_s) begin
            addr_r   <= req_addr;
            size_r   <= req_size;
            strobe_r <= req_strobe;
            data_r   <= req_data;
        end
    end

    // Registered response outputs, timed to the ACK and DONE states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_ok_r <= 1'b0;
            data_ok_r <= 1'b0;
            rdata_r   <= 64'd0;
        end else begin
            addr_ok_r <= (state_s == ACK);
            data_ok_r <= (state_s == DONE);
            if ((state_s == DONE) && !is_write_s && access_ok_s) begin
                rdata_r <= mem[idx_s];
            end else begin
                rdata_r <= 64'd0;
            end
        end
    end

    // Byte-strobed write commit at the edge ending DONE; the array is never reset.
    always_ff @(posedge clk) begin
        if ((state_r == DONE) && is_write_s && access_ok_s) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_r[i]) begin
                    mem[idx_s][8*i +: 8] <= data_r[8*i +: 8];
                end
            end
        end
    end

`ifdef DBUS_RESP_ERR_EN
    logic err_r;

    // Error flag accompanies data_ok for rejected accesses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= (state_s == DONE) && !access_ok_s;
        end
    end

    assign resp_err = err_r;
`endif

    assign resp_addr_ok = addr_ok_r;
    assign resp_data_ok = data_ok_r;
    assign resp_data    = rdata_r;

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder: three instances (LATENCY 2, 1, 15),
// a cycle-level transaction model, and directed vectors with literal expectations.
module tb_dbus_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rv    [3];
    logic [63:0] ra    [3];
    logic [2:0]  rs    [3];
    logic [7:0]  rstb  [3];
    logic [63:0] rdin  [3];
    logic        aok   [3];
    logic        dok   [3];
    logic [63:0] rdat  [3];
    logic        err   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dbus_responder #(.LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
            .clk          (clk),
            .reset        (reset),
            .req_valid    (rv[g]),
            .req_addr     (ra[g]),
            .req_size     (rs[g]),
            .req_strobe   (rstb[g]),
            .req_data     (rdin[g]),
            .resp_addr_ok (aok[g]),
            .resp_data_ok (dok[g]),
            .resp_data    (rdat[g])
`ifdef DBUS_RESP_ERR_EN
            ,
            .resp_err     (err[g])
`endif
        );
`ifndef DBUS_RESP_ERR_EN
        assign err[g] = 1'b0;
`endif
    end

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          busy [3];
    int          acc  [3];
    int          rdy  [3];
    logic [63:0] ma   [3];
    logic [2:0]  msz  [3];
    logic [7:0]  ms   [3];
    logic [63:0] md   [3];
    logic [63:0] mm   [3][1024];

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'd8192);
    endfunction

    function automatic bit acc_ok(input logic [63:0] a, input logic [2:0] sz);
`ifdef DBUS_RESP_ERR_EN
        int bytes;
        bytes = (sz >= 3'd3) ? 8 : (1 << sz);
        return in_rng(a) && ((a % 64'(bytes)) == 64'd0);
`else
        return in_rng(a) && (sz == sz);
`endif
    endfunction

    function automatic logic [63:0] exp_read(input int k);
        if (ms[k] != 8'd0 || !acc_ok(ma[k], msz[k])) return 64'd0;
        return mm[k][(ma[k] - BASE) / 64'd8];
    endfunction

    always @(posedge clk or negedge reset) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                busy[k] = 1'b0;
                rdy[k]  = 0;
            end else begin
                if (busy[k] && cyc == acc[k] + lat_of(k) + 1) begin
                    if (acc_ok(ma[k], msz[k])) begin
                        for (int b = 0; b < 8; b++)
                            if (ms[k][b]) mm[k][(ma[k] - BASE) / 64'd8][8*b +: 8] = md[k][8*b +: 8];
                    end
                    busy[k] = 1'b0;
                    rdy[k]  = cyc + 2;
                end
                if (!busy[k] && cyc >= rdy[k] && rv[k]) begin
                    busy[k] = 1'b1;
                    acc[k]  = cyc;
                    ma[k]   = ra[k];
                    msz[k]  = rs[k];
                    ms[k]   = rstb[k];
                    md[k]   = rdin[k];
                end
            end
        end
    end

    // Per-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                bit e_aok, e_dok, e_err;
                e_aok = busy[k] && (cyc == acc[k]);
                e_dok = busy[k] && (cyc == acc[k] + lat_of(k));
                e_err = e_dok && !acc_ok(ma[k], msz[k]);
                checks++;
                if (aok[k] !== e_aok) begin
                    errors++;
                    $display("FAIL addr_ok[%0d] cyc %0d: got %b want %b", k, cyc, aok[k], e_aok);
                end
                checks++;
                if (dok[k] !== e_dok) begin
                    errors++;
                    $display("FAIL data_ok[%0d] cyc %0d: got %b want %b", k, cyc, dok[k], e_dok);
                end
                if (e_dok) begin
                    checks++;
                    if (rdat[k] !== exp_read(k)) begin
                        errors++;
                        $display("FAIL resp_data[%0d] cyc %0d: got %h want %h", k, cyc, rdat[k], exp_read(k));
                    end
                end
`ifdef DBUS_RESP_ERR_EN
                checks++;
                if (err[k] !== e_err) begin
                    errors++;
                    $display("FAIL resp_err[%0d] cyc %0d: got %b want %b", k, cyc, err[k], e_err);
                end
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic xact(input int k, input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, input logic [2:0] sz,
                        output logic [63:0] rd, output int lat);
        int t_aok;
        t_aok = -1;
        lat   = -1;
        rd    = 64'd0;
        @(negedge clk);
        rv[k] = 1'b1; ra[k] = a; rstb[k] = s; rdin[k] = d; rs[k] = sz;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (aok[k]) t_aok = n;
            if (dok[k]) begin
                rd  = rdat[k];
                lat = n - t_aok;
                break;
            end
        end
        rv[k] = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout[%0d]: got no data_ok want data_ok within 64 cycles", k);
        end
    endtask

    logic [63:0] rd;
    int          lat;
    int          t1, t2, na, nd;
    bit          seen;

    initial begin
        for (int k = 0; k < 3; k++) begin
            rv[k] = 1'b0; ra[k] = 64'd0; rs[k] = 3'd3; rstb[k] = 8'd0; rdin[k] = 64'd0;
        end
        repeat (3) @(negedge clk);
        chk("reset addr_ok", {63'd0, aok[0]}, 64'd0);
        chk("reset data_ok", {63'd0, dok[0]}, 64'd0);
        chk("reset resp_data", rdat[0], 64'd0);
        chk("reset resp_err", {63'd0, err[0]}, 64'd0);
        reset = 1'b1;

        // write then read, LATENCY 2
        xact(0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 3'd3, rd, lat);
        chk("write latency", 64'(lat), 64'd2);
        xact(0, 64'h8000_0010, 8'h00, 64'd0, 3'd3, rd, lat);
        chk("read after write", rd, 64'h1122_3344_5566_7788);
        chk("read latency", 64'(lat), 64'd2);

        // partial strobe
        xact(0, 64'h8000_0008, 8'hFF, 64'd0, 3'd3, rd, lat);
        xact(0, 64'h8000_0008, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 3'd3, rd, lat);
        xact(0, 64'h8000_0008, 8'h00, 64'd0, 3'd3, rd, lat);
        chk("partial strobe", rd, 64'h0000_0000_CCCC_DDDD);

        // out of range
        xact(0, 64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, 3'd3, rd, lat);
        xact(0, 64'h7FFF_FFF8, 8'h00, 64'd0, 3'd3, rd, lat);
        chk("oor read", rd, 64'd0);
        xact(0, 64'h8000_2000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 3'd3, rd, lat);
        xact(0, 64'h8000_0000, 8'h00, 64'd0, 3'd3, rd, lat);
        chk("oor write dropped", rd, 64'h0123_4567_89AB_CDEF);

        // misaligned 4-byte write
        xact(0, 64'h8000_0012, 8'h30, 64'h0000_9999_0000_0000, 3'd2, rd, lat);
        xact(0, 64'h8000_0010, 8'h00, 64'd0, 3'd3, rd, lat);
`ifdef DBUS_RESP_ERR_EN
        chk("misaligned write", rd, 64'h1122_3344_5566_7788);
`else
        chk("misaligned write", rd, 64'h1122_9999_5566_7788);
`endif

        // reset during WAIT of a write
        @(negedge clk);
        rv[0] = 1'b1; ra[0] = 64'h8000_0000; rstb[0] = 8'hFF; rdin[0] = 64'hFFFF_0000_FFFF_0000; rs[0] = 3'd3;
        seen = 1'b0;
        for (int n = 0; n < 16 && !seen; n++) begin
            @(negedge clk);
            if (aok[0]) seen = 1'b1;
        end
        chk("mid-op addr_ok seen", {63'd0, seen}, 64'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid-op reset addr_ok", {63'd0, aok[0]}, 64'd0);
        chk("mid-op reset data_ok", {63'd0, dok[0]}, 64'd0);
        chk("mid-op reset resp_data", rdat[0], 64'd0);
        rv[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        xact(0, 64'h8000_0000, 8'h00, 64'd0, 3'd3, rd, lat);
        chk("abandoned write", rd, 64'h0123_4567_89AB_CDEF);

        // back-to-back reads with req_valid held
        @(negedge clk);
        rv[0] = 1'b1; ra[0] = 64'h8000_0010; rstb[0] = 8'h00; rs[0] = 3'd3;
        na = 0; nd = 0; t1 = -1; t2 = -1;
        for (int n = 0; n < 40 && nd < 2; n++) begin
            @(negedge clk);
            if (aok[0]) begin
                na++;
                if (t1 < 0) t1 = n;
                else t2 = n;
            end
            if (dok[0]) nd++;
        end
        rv[0] = 1'b0;
        chk("b2b spacing", 64'(t2 - t1), 64'd5);
        chk("b2b addr_ok count", 64'(na), 64'd2);
        chk("b2b data_ok count", 64'(nd), 64'd2);

        // latency sweep
        xact(1, 64'h8000_0020, 8'hFF, 64'hCAFE_F00D_1234_5678, 3'd3, rd, lat);
        xact(1, 64'h8000_0020, 8'h00, 64'd0, 3'd3, rd, lat);
        chk("lat1 data", rd, 64'hCAFE_F00D_1234_5678);
        chk("lat1 spacing", 64'(lat), 64'd1);
        xact(2, 64'h8000_1FF8, 8'hFF, 64'h0F0F_0F0F_A5A5_A5A5, 3'd3, rd, lat);
        xact(2, 64'h8000_1FF8, 8'h00, 64'd0, 3'd3, rd, lat);
        chk("lat15 data", rd, 64'h0F0F_0F0F_A5A5_A5A5);
        chk("lat15 spacing", 64'(lat), 64'd15);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
